aes_round_controller: RTL

//  Iterative AES round sequencer. Accepts one 128-bit block plus direction over a valid/ready

---
 rtl/aes_round_controller_pkg.sv | 92 +++++++++
 rtl/aes_round_controller_datapath.sv | 44 ++++
 rtl/aes_round_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/aes_round_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_round_controller_pkg                                                   |
// | Shared types and GF(2^8) helpers for the iterative AES round sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_round_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    typedef logic [127:0] block_t;

    localparam int NR_MAX = 14;

    function automatic int nr_for_key(input int key_bits);
        case (key_bits)
            192:     return 12;
            256:     return 14;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned s);
        return (v << s) | (v >> (8 - s));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] mix_coef(input int k, input logic inv);
        case (k)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    // One state column, byte 0 in the top bits; circulant matrix row r is coef[(j-r) mod 4].
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [31:0] res;
        logic [7:0]  acc;
        res = 32'h0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ gf_mul(col[31-8*j -: 8], mix_coef((j - r + 4) % 4, inv));
            end
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_controller_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_round_datapath                                                         |
// | Combinational single AES round, forward or inverse, MixColumns optional.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_round_datapath
    import aes_round_controller_pkg::*;
(
    input  logic   i_decrypt,
    input  logic   i_mix,
    input  block_t i_state,
    input  block_t i_round_key,
    output block_t o_state
);

    block_t w_enc_sr;
    block_t w_dec_sr;
    block_t w_mix_in;
    block_t w_mixed;
    block_t w_pre_key;

    // SubBytes commutes with ShiftRows, so each output byte is a substituted, relocated input byte.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int c_ROW     = i % 4;
        localparam int c_COL     = i / 4;
        localparam int c_SRC_FWD = c_ROW + 4 * ((c_COL + c_ROW) % 4);
        localparam int c_SRC_INV = c_ROW + 4 * ((c_COL - c_ROW + 4) % 4);
        assign w_enc_sr[127-8*i -: 8] = sbox_fwd(i_state[127-8*c_SRC_FWD -: 8]);
        assign w_dec_sr[127-8*i -: 8] = sbox_inv(i_state[127-8*c_SRC_INV -: 8]);
    end

    // Encrypt mixes before the key add, decrypt after it; one shared mixer serves both.
    assign w_mix_in = i_decrypt ? (w_dec_sr ^ i_round_key) : w_enc_sr;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_mixed[127-32*c -: 32] = mix_col(w_mix_in[127-32*c -: 32], i_decrypt);
    end

    assign w_pre_key = i_mix ? w_mixed : w_mix_in;
    assign o_state   = i_decrypt ? w_pre_key : (w_pre_key ^ i_round_key);

endmodule
`default_nettype wire

// File: rtl/aes_round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_round_controller                                                       |
// | Iterative AES round sequencer with valid/ready block and key interfaces.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_round_controller
    import aes_round_controller_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int RK_IDX_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic                in_decrypt,
    input  logic                rk_valid,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                out_decrypt,
    output logic                busy,
    output logic [RK_IDX_W-1:0] round_count
);

    localparam logic [RK_IDX_W-1:0] c_NR    = RK_IDX_W'(nr_for_key(KEY_BITS));
    localparam logic [RK_IDX_W-1:0] c_ONE   = RK_IDX_W'(1);
    localparam logic [RK_IDX_W-1:0] c_NR_M1 = c_NR - c_ONE;

    ctrl_state_t         ctrl_q, ctrl_d;
    block_t              data_q, data_d;
    logic                dir_q, dir_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    block_t              w_round_out;
    logic                w_accept;

    aes_round_datapath u_datapath (
        .i_decrypt   (dir_q),
        .i_mix       (ctrl_q == ROUND),
        .i_state     (data_q),
        .i_round_key (rk_data),
        .o_state     (w_round_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q <= IDLE;
            data_q <= '0;
            dir_q  <= 1'b0;
            rnd_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            dir_q  <= dir_d;
            rnd_q  <= rnd_d;
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        dir_d    = dir_q;
        rnd_d    = rnd_q;
        w_accept = 1'b0;
        case (ctrl_q)
            IDLE: w_accept = in_valid && rk_valid;
            ROUND: begin
                if (rk_valid) begin
                    data_d = w_round_out;
                    if (!dir_q) begin
                        if (rnd_q == c_NR_M1) ctrl_d = FINAL;
                        else                  rnd_d  = rnd_q + c_ONE;
                    end else begin
                        if (rnd_q == c_ONE)   ctrl_d = FINAL;
                        else                  rnd_d  = rnd_q - c_ONE;
                    end
                end
            end
            FINAL: begin
                if (rk_valid) begin
                    data_d = w_round_out;
                    ctrl_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ctrl_d   = IDLE;
                    w_accept = in_valid && rk_valid;
                end
            end
            default: ctrl_d = IDLE;
        endcase
        // A new block can load from IDLE or straight out of DONE in the cycle its result leaves.
        if (w_accept) begin
            ctrl_d = ROUND;
            data_d = in_data ^ rk_data;
            dir_d  = in_decrypt;
            rnd_d  = in_decrypt ? c_NR_M1 : c_ONE;
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        rk_idx      = in_decrypt ? c_NR : '0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        round_count = '0;
        out_data    = '0;
        case (ctrl_q)
            IDLE: in_ready = rk_valid;
            ROUND: begin
                rk_idx      = rnd_q;
                busy        = 1'b1;
                round_count = rnd_q;
            end
            FINAL: begin
                rk_idx      = dir_q ? '0 : c_NR;
                busy        = 1'b1;
                round_count = dir_q ? '0 : c_NR;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = data_q;
                in_ready  = out_ready && rk_valid;
            end
            default: ;
        endcase
        // Handshake outputs that follow inputs are forced quiet while reset is held.
        if (reset) begin
            in_ready = 1'b0;
            rk_idx   = '0;
        end
    end

    assign out_decrypt = dir_q;

endmodule
`default_nettype wire
